// File: rtl/piano_tone_gen.sv
// piano_tone_gen: picks the lowest pressed key (C4..C5) and drives SPEAKER with a 50%-duty square wave.
// Optional release tail: define TONE_SUSTAIN_EN to keep the last note sounding for SUSTAIN_MS after release.
module piano_tone_gen #(
   parameter int unsigned CLK_HZ     = 100_000_000,
   parameter int unsigned CNT_W      = 18,
   parameter int unsigned SUSTAIN_MS = 200
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [7:0] KEY,
   output logic       SPEAKER,
   output logic       NOTE_ACTIVE,
   output logic [2:0] NOTE_IDX
);

   // Note pitches in centi-Hz, C4 through C5
   localparam int unsigned F100 [8] = '{26163, 29366, 32963, 34923, 39200, 44000, 49388, 52325};

   function automatic logic [CNT_W-1:0] hp_calc(input longint unsigned f100);
      longint unsigned q;
      q = (64'(CLK_HZ) * 64'd100) / (64'd2 * f100);
      return q[CNT_W-1:0];
   endfunction

`ifdef TONE_SUSTAIN_EN
   localparam longint unsigned SUSTAIN_CYC = (64'(SUSTAIN_MS) * 64'(CLK_HZ)) / 64'd1000;
   localparam int TMR_W = $clog2(SUSTAIN_CYC + 64'd1);
   typedef enum logic [1:0] {S_IDLE, S_PLAY, S_SUSTAIN} state_t;
   logic [TMR_W-1:0] timer_q, timer_d;
`else
   typedef enum logic [1:0] {S_IDLE, S_PLAY} state_t;
`endif

   state_t           state_q, state_d;
   logic [7:0]       key_s1_q, key_s_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             speaker_q, speaker_d;
   logic             active_q, active_d;
   logic [2:0]       note_idx_q, note_idx_d;
   logic [2:0]       pending_q, pending_d;

   logic [CNT_W-1:0] hp_tab [8];
   logic [CNT_W-1:0] hp_cur;
   logic             term;
   logic             key_any;
   logic [2:0]       winner;

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_hp
         assign hp_tab[gi] = hp_calc(64'(F100[gi]));
      end
   endgenerate

   assign hp_cur  = hp_tab[note_idx_q];
   assign term    = (cnt_q == hp_cur - CNT_W'(1));
   assign key_any = |key_s_q;

   // Lowest set bit wins
   always_comb begin
      winner = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (key_s_q[i]) winner = 3'(i);
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      speaker_d  = speaker_q;
      active_d   = active_q;
      note_idx_d = note_idx_q;
      pending_d  = key_any ? winner : pending_q;
`ifdef TONE_SUSTAIN_EN
      timer_d    = timer_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            cnt_d     = '0;
            speaker_d = 1'b0;
            if (key_any) begin
               state_d    = S_PLAY;
               note_idx_d = winner;
               active_d   = 1'b1;
            end
         end
         S_PLAY: begin
            cnt_d = term ? '0 : cnt_q + CNT_W'(1);
`ifdef TONE_SUSTAIN_EN
            if (!key_any) begin
               state_d = S_SUSTAIN;
               timer_d = TMR_W'(SUSTAIN_CYC);
            end
            if (term) begin
               speaker_d  = ~speaker_q;
               note_idx_d = pending_d;
            end
`else
            if (key_any) begin
               if (term) begin
                  speaker_d  = ~speaker_q;
                  note_idx_d = pending_d;
               end
            end else if (term) begin
               // Drain: a high half-period ends low, a low one simply stays low
               speaker_d = 1'b0;
               active_d  = 1'b0;
               state_d   = S_IDLE;
            end
`endif
         end
`ifdef TONE_SUSTAIN_EN
         S_SUSTAIN: begin
            cnt_d = term ? '0 : cnt_q + CNT_W'(1);
            if (key_any) begin
               state_d = S_PLAY;
               timer_d = '0;
               if (term) begin
                  speaker_d  = ~speaker_q;
                  note_idx_d = pending_d;
               end
            end else if (timer_q == '0) begin
               if (term) begin
                  speaker_d = 1'b0;
                  active_d  = 1'b0;
                  state_d   = S_IDLE;
               end
            end else begin
               timer_d = timer_q - TMR_W'(1);
               if (term) begin
                  speaker_d  = ~speaker_q;
                  note_idx_d = pending_d;
               end
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q    <= S_IDLE;
         key_s1_q   <= '0;
         key_s_q    <= '0;
         cnt_q      <= '0;
         speaker_q  <= 1'b0;
         active_q   <= 1'b0;
         note_idx_q <= 3'd0;
         pending_q  <= 3'd0;
`ifdef TONE_SUSTAIN_EN
         timer_q    <= '0;
`endif
      end else begin
         state_q    <= state_d;
         key_s1_q   <= KEY;
         key_s_q    <= key_s1_q;
         cnt_q      <= cnt_d;
         speaker_q  <= speaker_d;
         active_q   <= active_d;
         note_idx_q <= note_idx_d;
         pending_q  <= pending_d;
`ifdef TONE_SUSTAIN_EN
         timer_q    <= timer_d;
`endif
      end
   end

   assign SPEAKER     = speaker_q;
   assign NOTE_ACTIVE = active_q;
   assign NOTE_IDX    = note_idx_q;

endmodule

// File: tb/tb_piano_tone_gen.sv
// Scoreboard bench for piano_tone_gen: stimulus queues expected output changes (cycle, SPEAKER,
// NOTE_ACTIVE, NOTE_IDX); a negedge monitor pops and compares on every observed output change.
module tb_piano_tone_gen;

   localparam int unsigned CLK_HZ     = 1_000_000;
   localparam int unsigned CNT_W      = 18;
   localparam int unsigned SUSTAIN_MS = 2;
   localparam int HP_C4 = 1911;
   localparam int HP_G4 = 1275;
   localparam int HP_A4 = 1136;
   localparam int HP_C5 = 955;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] key = 8'h00;
   logic       spk;
   logic       act;
   logic [2:0] idx;

   always #5 clk = ~clk;

   piano_tone_gen #(
      .CLK_HZ     (CLK_HZ),
      .CNT_W      (CNT_W),
      .SUSTAIN_MS (SUSTAIN_MS)
   ) dut (
      .CLK         (clk),
      .RESET       (rst),
      .KEY         (key),
      .SPEAKER     (spk),
      .NOTE_ACTIVE (act),
      .NOTE_IDX    (idx)
   );

   typedef struct {
      int         cyc;
      logic       spk;
      logic       act;
      logic [2:0] idx;
   } ev_t;

   ev_t exp_q[$];
   int  cyc      = 0;
   int  checks   = 0;
   int  failures = 0;
   bit  mon_en   = 1'b0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor: every change of the output triple must match the head of the expectation queue
   initial begin
      logic       p_spk;
      logic       p_act;
      logic [2:0] p_idx;
      ev_t        e;
      p_spk = 1'b0;
      p_act = 1'b0;
      p_idx = 3'd0;
      forever begin
         @(negedge clk);
         if (mon_en && !rst) begin
            if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
               e = exp_q.pop_front();
               checks++;
               failures++;
               $display("FAIL missed_event: no output change by cycle %0d, required spk=%0b act=%0b idx=%0d at cycle %0d",
                        cyc, e.spk, e.act, e.idx, e.cyc);
            end
            if ({spk, act, idx} !== {p_spk, p_act, p_idx}) begin
               checks++;
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("FAIL unexpected_change: cycle %0d got spk=%0b act=%0b idx=%0d, required no change",
                           cyc, spk, act, idx);
               end else begin
                  e = exp_q.pop_front();
                  if (e.cyc != cyc || e.spk !== spk || e.act !== act || e.idx !== idx) begin
                     failures++;
                     $display("FAIL output_event: got cycle %0d spk=%0b act=%0b idx=%0d, required cycle %0d spk=%0b act=%0b idx=%0d",
                              cyc, spk, act, idx, e.cyc, e.spk, e.act, e.idx);
                  end else begin
                     $display("event ok: cycle %0d spk=%0b act=%0b idx=%0d", cyc, spk, act, idx);
                  end
               end
            end
         end
         p_spk = spk;
         p_act = act;
         p_idx = idx;
      end
   end

   task automatic wait_until(input int c);
      do begin
         @(posedge clk);
         #1;
      end while (cyc < c);
   endtask

   task automatic expect_ev(input int c, input logic s, input logic a, input logic [2:0] i);
      ev_t e;
      e.cyc = c;
      e.spk = s;
      e.act = a;
      e.idx = i;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] req);
      checks++;
      if (got !== req) begin
         failures++;
         $display("FAIL %s: got %0d required %0d", name, got, req);
      end else begin
         $display("check ok: %s = %0d", name, got);
      end
   endtask

   initial begin
      int k;
      int t1;
      int b;
      int c;
      int r5;
`ifdef TONE_SUSTAIN_EN
      int a;
`endif
      // Reset state and idle silence
      rst = 1'b1;
      key = 8'h00;
      wait_until(3);
      rst = 1'b0;
      #1;
      chk("reset_speaker", {7'd0, spk}, 8'd0);
      chk("reset_active",  {7'd0, act}, 8'd0);
      chk("reset_idx",     {5'd0, idx}, 8'd0);
      mon_en = 1'b1;
      wait_until(cyc + 10000);

      // A4 held: active three edges after the key change, 1136-cycle half-periods
      k  = cyc;
      key = 8'h20;
      expect_ev(k + 3, 1'b0, 1'b1, 3'd5);
      expect_ev(k + 3 + HP_A4, 1'b1, 1'b1, 3'd5);
      expect_ev(k + 3 + 2 * HP_A4, 1'b0, 1'b1, 3'd5);
      t1 = k + 3 + 3 * HP_A4;
      expect_ev(t1, 1'b1, 1'b1, 3'd5);
      wait_until(t1 + 100);
      key = 8'h00;
`ifdef TONE_SUSTAIN_EN
      // Sustain tail: tone keeps going for 2000 cycles, then ends at the next terminal
      expect_ev(t1 + HP_A4, 1'b0, 1'b1, 3'd5);
      expect_ev(t1 + 2 * HP_A4, 1'b0, 1'b0, 3'd5);
      wait_until(t1 + 2 * HP_A4 + 50);
      k  = cyc;
      key = 8'h20;
      expect_ev(k + 3, 1'b0, 1'b1, 3'd5);
      a = k + 3 + HP_A4;
      expect_ev(a, 1'b1, 1'b1, 3'd5);
      wait_until(a + 100);
      key = 8'h00;
      wait_until(a + 1103);
      key = 8'h10;
      expect_ev(a + HP_A4, 1'b0, 1'b1, 3'd4);
      expect_ev(a + HP_A4 + HP_G4, 1'b1, 1'b1, 3'd4);
      wait_until(a + HP_A4 + HP_G4 + 100);
      key = 8'h00;
      expect_ev(a + HP_A4 + 2 * HP_G4, 1'b0, 1'b1, 3'd4);
      expect_ev(a + HP_A4 + 3 * HP_G4, 1'b0, 1'b0, 3'd4);
      wait_until(a + HP_A4 + 3 * HP_G4 + 2000);
`else
      // Release while high: SPEAKER and NOTE_ACTIVE fall together at the current terminal
      expect_ev(t1 + HP_A4, 1'b0, 1'b0, 3'd5);
      wait_until(t1 + HP_A4 + 3000);
`endif

      // C4 beats C5; switching to C5 mid half-period keeps that half-period at 1911
      k  = cyc;
      key = 8'h81;
      expect_ev(k + 3, 1'b0, 1'b1, 3'd0);
      b = k + 3 + HP_C4;
      expect_ev(b, 1'b1, 1'b1, 3'd0);
      wait_until(b + 500);
      key = 8'h80;
      expect_ev(b + HP_C4, 1'b0, 1'b1, 3'd7);
      c = b + HP_C4 + HP_C5;
      expect_ev(c, 1'b1, 1'b1, 3'd7);

      // Asynchronous reset between edges while SPEAKER is high
      wait_until(c + 200);
      chk("pre_reset_speaker", {7'd0, spk}, 8'd1);
      #1;
      rst = 1'b1;
      #1;
      chk("async_reset_speaker", {7'd0, spk}, 8'd0);
      chk("async_reset_active",  {7'd0, act}, 8'd0);
      chk("async_reset_idx",     {5'd0, idx}, 8'd0);
      wait_until(cyc + 3);
      rst = 1'b0;
      r5 = cyc;
      expect_ev(r5 + 3, 1'b0, 1'b1, 3'd7);
      expect_ev(r5 + 3 + HP_C5, 1'b1, 1'b1, 3'd7);
      wait_until(r5 + 3 + HP_C5 + 20);

      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL pending_events: got %0d outstanding, required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
